spu_sram_sequencer: RTL



---
 rtl/spu_sram_sequencer.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/spu_sram_sequencer.sv
// Address sequencer for the SRAM-to-SRAM evaluation datapath: streams source
// words into the SPU pipeline and writes returned results to the destination SRAMs.
module spu_sram_sequencer #(
  parameter int unsigned WB_ADR_WIDTH   = 37,
  parameter int unsigned WB_DAT_WIDTH   = 64,
  parameter int unsigned MEM_ADDR_WIDTH = 10,
  parameter int unsigned READ_LATENCY   = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,

  input  logic [WB_ADR_WIDTH-1:0]   s_wb_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   s_wb_dat_i,
  output logic [WB_DAT_WIDTH-1:0]   s_wb_dat_o,
  input  logic [WB_DAT_WIDTH/8-1:0] s_wb_sel_i,
  input  logic                      s_wb_we_i,
  input  logic                      s_wb_stb_i,
  output logic                      s_wb_ack_o,

  output logic                      m_src_en,
  output logic [MEM_ADDR_WIDTH-1:0] m_src_addr,
  input  logic [WB_DAT_WIDTH-1:0]   m_src0_rdata,
  input  logic [WB_DAT_WIDTH-1:0]   m_src1_rdata,

  output logic                      m_pipe_valid,
  output logic [WB_DAT_WIDTH-1:0]   m_pipe_data0,
  output logic [WB_DAT_WIDTH-1:0]   m_pipe_data1,

  input  logic                      s_res_valid,
  input  logic [WB_DAT_WIDTH-1:0]   s_res_data0,
  input  logic [WB_DAT_WIDTH-1:0]   s_res_data1,

  output logic                      m_dst_we,
  output logic [MEM_ADDR_WIDTH-1:0] m_dst_addr,
  output logic [WB_DAT_WIDTH-1:0]   m_dst_wdata0,
  output logic [WB_DAT_WIDTH-1:0]   m_dst_wdata1,

  output logic                      busy
);

  localparam int unsigned CNT_W = 11;
  localparam int unsigned SEL_W = WB_DAT_WIDTH / 8;
  localparam logic [CNT_W-1:0] SIZE_MAX = 11'd1024;

  localparam logic [1:0] REG_CTL    = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_SIZE   = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        rd_cnt;
  logic [CNT_W-1:0]        wr_cnt;
  logic [CNT_W-1:0]        size_q;
  logic                    done;
  logic                    start_req;
  logic [READ_LATENCY-1:0] vpipe;

  logic                    wb_acc;
  logic                    wb_wr;
  logic [1:0]              wb_reg;
  logic [CNT_W-1:0]        size_wr;
  logic                    res_ok;
  logic                    wr_last;
  logic                    unused;

  assign wb_acc = s_wb_stb_i && !s_wb_ack_o;
  assign wb_wr  = wb_acc && s_wb_we_i && s_wb_sel_i[0];
  assign wb_reg = s_wb_adr_i[1:0];

  assign unused = ^{s_wb_adr_i[WB_ADR_WIDTH-1:2], s_wb_sel_i[SEL_W-1:1]};

  // Anything wider than a full SRAM is clamped to the SRAM depth.
  assign size_wr = ((|s_wb_dat_i[WB_DAT_WIDTH-1:CNT_W]) ||
                    (s_wb_dat_i[CNT_W-1:0] > SIZE_MAX)) ? SIZE_MAX
                                                         : s_wb_dat_i[CNT_W-1:0];

  // Results are taken only while a job is active and the destination is not yet full.
  assign res_ok  = s_res_valid && ((state == RUN) || (state == DRAIN)) && (wr_cnt != size_q);

  // Looking one write ahead lets done follow the final destination write by one cycle.
  assign wr_last = (wr_cnt == size_q) || (res_ok && ((wr_cnt + CNT_W'(1)) == size_q));

  // Wishbone register window: two-cycle access with side effects on the ack edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_wb_ack_o <= 1'b0;
      s_wb_dat_o <= '0;
      size_q     <= SIZE_MAX;
      start_req  <= 1'b0;
    end else begin
      s_wb_ack_o <= wb_acc;
      start_req  <= wb_wr && (wb_reg == REG_CTL) && s_wb_dat_i[0];
      s_wb_dat_o <= '0;
      if (wb_acc && !s_wb_we_i) begin
        case (wb_reg)
          REG_CTL:    s_wb_dat_o <= WB_DAT_WIDTH'(busy);
          REG_STATUS: s_wb_dat_o <= WB_DAT_WIDTH'(done);
          REG_SIZE:   s_wb_dat_o <= WB_DAT_WIDTH'(size_q);
          default:    s_wb_dat_o <= '0;
        endcase
      end
      if (wb_wr && (wb_reg == REG_SIZE) && (state == IDLE)) begin
        size_q <= size_wr;
      end
    end
  end

  // Sequencer FSM with the read-address and write-side outputs it drives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rd_cnt       <= '0;
      wr_cnt       <= '0;
      m_src_en     <= 1'b0;
      m_src_addr   <= '0;
      m_dst_we     <= 1'b0;
      m_dst_addr   <= '0;
      m_dst_wdata0 <= '0;
      m_dst_wdata1 <= '0;
    end else begin
      m_src_en <= 1'b0;
      m_dst_we <= 1'b0;

      if (res_ok) begin
        m_dst_we     <= 1'b1;
        m_dst_addr   <= MEM_ADDR_WIDTH'(wr_cnt);
        m_dst_wdata0 <= s_res_data0;
        m_dst_wdata1 <= s_res_data1;
        wr_cnt       <= wr_cnt + CNT_W'(1);
      end

      if (wb_wr && (wb_reg == REG_STATUS)) begin
        done <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_req) begin
            busy   <= 1'b1;
            done   <= 1'b0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            if (size_q != '0) begin
              state      <= RUN;
              m_src_en   <= 1'b1;
              m_src_addr <= '0;
              rd_cnt     <= CNT_W'(1);
            end else begin
              // A zero-length job has nothing to read and falls through the drain check.
              state <= DRAIN;
            end
          end
        end
        RUN: begin
          if (rd_cnt == size_q) begin
            state <= DRAIN;
          end else begin
            m_src_en   <= 1'b1;
            m_src_addr <= MEM_ADDR_WIDTH'(rd_cnt);
            rd_cnt     <= rd_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (wr_last) begin
            state <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return alignment: the enable is delayed to match the SRAM latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vpipe        <= '0;
      m_pipe_valid <= 1'b0;
      m_pipe_data0 <= '0;
      m_pipe_data1 <= '0;
    end else begin
      vpipe        <= READ_LATENCY'({vpipe, m_src_en});
      m_pipe_valid <= vpipe[READ_LATENCY-1];
      if (vpipe[READ_LATENCY-1]) begin
        m_pipe_data0 <= m_src0_rdata;
        m_pipe_data1 <= m_src1_rdata;
      end
    end
  end

endmodule
